mem_bus_ctrl: RTL

//  Timing sequencer downstream of the MEM stage; owns RAM1 and the UART, which share one 16-bit data bus.

---
 rtl/mem_bus_ctrl_if.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Pipeline-side request/response signals plus the RAM1/UART strobes and status pins.
// The shared tristate data bus is kept out of the interface and stays a plain inout port.
interface mem_bus_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        ram1_en;
  logic        ram1_oe;
  logic        ram1_we;
  logic [15:0] ram1_addr;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_data_ready;
  logic        uart_tbre;
  logic        uart_tsre;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  uart_data_ready, uart_tbre, uart_tsre,
    output stall, rdata, rdata_valid,
    output ram1_en, ram1_oe, ram1_we, ram1_addr,
    output uart_rdn, uart_wrn
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output uart_data_ready, uart_tbre, uart_tsre,
    input  stall, rdata, rdata_valid,
    input  ram1_en, ram1_oe, ram1_we, ram1_addr,
    input  uart_rdn, uart_wrn
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Sequences MEM-stage loads/stores into timed RAM1 and UART strobe patterns on a shared 16-bit bus.
// All strobes and the bus enable decode from the state register only; stall is the one combinational output.
module mem_bus_ctrl #(
  parameter logic [15:0] ADDR_SERIAL_PORT   = 16'hBF00,
  parameter logic [15:0] ADDR_SERIAL_STATUS = 16'hBF01,
  parameter int          RAM_RD_CYCLES      = 2,
  parameter int          RAM_WR_CYCLES      = 2,
  parameter int          UART_RD_CYCLES     = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.slave bus,
  inout  wire  [15:0]   ram1_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_RAM_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD,
    S_U_RD_WAIT, S_U_RD, S_U_WR, S_U_WR_WAIT, S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_write;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [15:0] r_ram1_addr;

  logic w_accept, w_is_port, w_is_status;
  logic w_rd_last, w_wr_last, w_urd_last;
  logic w_uart_state, w_drive;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_is_port   = (bus.req_addr == ADDR_SERIAL_PORT);
  assign w_is_status = (bus.req_addr == ADDR_SERIAL_STATUS);
  assign w_rd_last   = (r_cnt == 8'(RAM_RD_CYCLES - 1));
  assign w_wr_last   = (r_cnt == 8'(RAM_WR_CYCLES - 1));
  assign w_urd_last  = (r_cnt == 8'(UART_RD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt counts cycles spent in the current timed state and restarts at zero on every transition.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_is_port)        w_state_next = bus.req_write ? S_U_WR : S_U_RD_WAIT;
          else if (w_is_status) w_state_next = S_DONE;
          else                  w_state_next = bus.req_write ? S_WR_SETUP : S_RAM_RD;
        end
      end
      S_RAM_RD: begin
        if (w_rd_last) w_state_next = S_DONE;
        else           w_cnt_next   = r_cnt + 8'd1;
      end
      S_WR_SETUP: w_state_next = S_WR_PULSE;
      S_WR_PULSE: begin
        if (w_wr_last) w_state_next = S_WR_HOLD;
        else           w_cnt_next   = r_cnt + 8'd1;
      end
      S_WR_HOLD:   w_state_next = S_DONE;
      S_U_RD_WAIT: if (bus.uart_data_ready) w_state_next = S_U_RD;
      S_U_RD: begin
        if (w_urd_last) w_state_next = S_DONE;
        else            w_cnt_next   = r_cnt + 8'd1;
      end
      S_U_WR:      w_state_next = S_U_WR_WAIT;
      S_U_WR_WAIT: if (bus.uart_tbre && bus.uart_tsre) w_state_next = S_DONE;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_ram1_addr <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_write     <= bus.req_write;
        r_wdata     <= bus.req_wdata;
        r_ram1_addr <= bus.req_addr;
      end
      if (w_accept && w_is_status && !bus.req_write)
        r_rdata <= {14'b0, bus.uart_data_ready, bus.uart_tbre & bus.uart_tsre};
      if (r_state == S_RAM_RD && w_rd_last)
        r_rdata <= ram1_data;
      if (r_state == S_U_RD && w_urd_last)
        r_rdata <= {8'h00, ram1_data[7:0]};
    end
  end

  assign w_uart_state = (r_state == S_U_RD_WAIT) || (r_state == S_U_RD) ||
                        (r_state == S_U_WR)      || (r_state == S_U_WR_WAIT);
  assign w_drive      = (r_state == S_WR_SETUP) || (r_state == S_WR_PULSE) ||
                        (r_state == S_WR_HOLD)  || (r_state == S_U_WR);

  // Stall is forced low while reset is held so an aborted access releases the pipeline at once.
  assign bus.stall       = !rst && (w_accept || ((r_state != S_IDLE) && (r_state != S_DONE)));
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = (r_state == S_DONE) && !r_write;
  assign bus.ram1_en     = w_uart_state;
  assign bus.ram1_oe     = (r_state != S_RAM_RD);
  assign bus.ram1_we     = (r_state != S_WR_PULSE);
  assign bus.ram1_addr   = r_ram1_addr;
  assign bus.uart_rdn    = (r_state != S_U_RD);
  assign bus.uart_wrn    = (r_state != S_U_WR);
  assign ram1_data       = w_drive ? r_wdata : 16'hzzzz;

endmodule
